// File: rtl/signed_display_scan.sv
// signed_display_scan: converts a two's-complement value to decimal with a
// sequential shift-add-3 engine and drives a multiplexed common-anode
// 7-segment bank (leading-zero blanking, minus sign, overflow dashes).
// Optional feature macro: DISPLAY_BRIGHTNESS_EN adds duty[2:0], which limits
// how long segments are lit within each digit slot.
// Handshake: load is sampled on a rising edge only while busy=0; a sampled
// load raises busy on that same edge, and busy falls on the edge that commits
// the new display image. Loads seen while busy=1 are dropped.
module signed_display_scan #(
    parameter int DIGITS     = 4,
    parameter int VALUE_W    = 8,
    parameter int SCAN_DIV   = 1000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [VALUE_W-1:0]  value,
    input  logic                load,
    input  logic                blank,
`ifdef DISPLAY_BRIGHTNESS_EN
    input  logic [2:0]          duty,
`endif
    output logic [6:0]          seg,
    output logic                dp,
    output logic [DIGITS-1:0]   dig_sel,
    output logic                busy,
    output logic                overflow
);

    // BCD digits needed for the full magnitude (extra ones detect overflow)
    localparam int BCD_D = (VALUE_W + 2) / 3;
    localparam int NB    = (BCD_D > DIGITS) ? BCD_D : DIGITS;
    localparam int CW    = $clog2(VALUE_W + 1);
    localparam int PW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW    = $clog2(DIGITS);
    localparam logic AL  = (ACTIVE_LOW != 0);
    localparam logic [6:0] MINUS = 7'h40;

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [VALUE_W-1:0]   mag;
    logic                 sign;
    logic [4*NB-1:0]      bcd;
    logic [4*NB-1:0]      bcd_add;
    logic [6:0]           pat [DIGITS];
    logic [6:0]           pat_nxt [DIGITS];
    logic                 dp_lit;
    logic                 ovf_nxt;

    logic [PW-1:0]        prescaler;
    logic [PW-1:0]        pre_nxt;
    logic [IW-1:0]        scan_idx;
    logic [IW-1:0]        idx_nxt;
    logic [DIGITS-1:0]    onehot;
    logic [6:0]           seg_lit;
    logic                 dp_on;
    logic                 bright;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 7'h3F;
            4'd1:    glyph = 7'h06;
            4'd2:    glyph = 7'h5B;
            4'd3:    glyph = 7'h4F;
            4'd4:    glyph = 7'h66;
            4'd5:    glyph = 7'h6D;
            4'd6:    glyph = 7'h7D;
            4'd7:    glyph = 7'h07;
            4'd8:    glyph = 7'h7F;
            4'd9:    glyph = 7'h6F;
            default: glyph = 7'h00;
        endcase
    endfunction

    // Add-3 correction applied to every BCD digit before each shift
    always_comb begin
        bcd_add = bcd;
        for (int i = 0; i < NB; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_add[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // Display image derived from the finished BCD result
    always_comb begin
        int msd;
        ovf_nxt = 1'b0;
        msd     = 0;
        for (int i = 0; i < NB; i++) begin
            if (bcd[4*i +: 4] != 4'd0) begin
                if (i >= DIGITS) ovf_nxt = 1'b1;
                if (sign && i >= DIGITS - 1) ovf_nxt = 1'b1;
            end
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] != 4'd0) msd = i;
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (ovf_nxt)
                pat_nxt[i] = MINUS;
            else if (i <= msd)
                pat_nxt[i] = glyph(bcd[4*i +: 4]);
            else if (sign && i == msd + 1)
                pat_nxt[i] = MINUS;
            else
                pat_nxt[i] = 7'h00;
        end
    end

    // Conversion FSM: capture, VALUE_W shift-add-3 steps, atomic commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            overflow <= 1'b0;
            cnt      <= '0;
            mag      <= '0;
            sign     <= 1'b0;
            bcd      <= '0;
            dp_lit   <= 1'b0;
            for (int i = 0; i < DIGITS; i++) pat[i] <= 7'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        sign  <= value[VALUE_W-1];
                        mag   <= value[VALUE_W-1] ? (~value + VALUE_W'(1)) : value;
                        bcd   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= CONV;
                    end
                end
                CONV: begin
                    bcd <= {bcd_add[4*NB-2:0], mag[VALUE_W-1]};
                    mag <= {mag[VALUE_W-2:0], 1'b0};
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(VALUE_W - 1)) state <= COMMIT;
                end
                COMMIT: begin
                    for (int i = 0; i < DIGITS; i++) pat[i] <= pat_nxt[i];
                    dp_lit   <= sign & ~ovf_nxt;
                    overflow <= ovf_nxt;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Next prescaler / scan index and the logical (lit-high) output image
    always_comb begin
        if (prescaler == PW'(SCAN_DIV - 1)) begin
            pre_nxt = '0;
            idx_nxt = (scan_idx == IW'(DIGITS - 1)) ? '0 : scan_idx + IW'(1);
        end else begin
            pre_nxt = prescaler + PW'(1);
            idx_nxt = scan_idx;
        end
        onehot          = '0;
        onehot[idx_nxt] = 1'b1;
`ifdef DISPLAY_BRIGHTNESS_EN
        bright = (int'(pre_nxt) < ((int'(duty) + 1) * SCAN_DIV) / 8);
`else
        bright = 1'b1;
`endif
        seg_lit = (blank || !bright) ? 7'h00 : pat[idx_nxt];
        dp_on   = !blank && bright && dp_lit && (idx_nxt == '0);
    end

    // Scan counters and output registers; dig_sel/seg/dp move on one edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
            scan_idx  <= '0;
            dig_sel   <= {{(DIGITS-1){AL}}, ~AL};
            seg       <= {7{AL}};
            dp        <= AL;
        end else begin
            prescaler <= pre_nxt;
            scan_idx  <= idx_nxt;
            dig_sel   <= onehot ^ {DIGITS{AL}};
            seg       <= seg_lit ^ {7{AL}};
            dp        <= dp_on ^ AL;
        end
    end

endmodule

// File: tb/tb_signed_display_scan.sv
// Bench for signed_display_scan: a 4-digit and a 2-digit instance with a
// short scan period, checked against a divide/modulo decimal model.
module tb_signed_display_scan;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] value;
    logic       load4, load2, blank;
    logic [2:0] duty;

    logic [6:0] seg4, seg2;
    logic       dp4, dp2, busy4, busy2, ovf4, ovf2;
    logic [3:0] dig4;
    logic [1:0] dig2;

    signed_display_scan #(.DIGITS(4), .VALUE_W(8), .SCAN_DIV(8), .ACTIVE_LOW(1)) dut4 (
        .clk(clk), .rst_n(rst_n), .value(value), .load(load4), .blank(blank),
`ifdef DISPLAY_BRIGHTNESS_EN
        .duty(duty),
`endif
        .seg(seg4), .dp(dp4), .dig_sel(dig4), .busy(busy4), .overflow(ovf4)
    );

    signed_display_scan #(.DIGITS(2), .VALUE_W(8), .SCAN_DIV(8), .ACTIVE_LOW(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .value(value), .load(load2), .blank(blank),
`ifdef DISPLAY_BRIGHTNESS_EN
        .duty(duty),
`endif
        .seg(seg2), .dp(dp2), .dig_sel(dig2), .busy(busy2), .overflow(ovf2)
    );

    // lit-high view of whichever instance is under test
    logic       sel2;
    wire  [6:0] seg_l  = sel2 ? ~seg2 : ~seg4;
    wire        dp_l   = sel2 ? ~dp2 : ~dp4;
    wire  [3:0] dsel_l = sel2 ? {2'b00, ~dig2} : ~dig4;
    wire        busy_w = sel2 ? busy2 : busy4;
    wire        ovf_w  = sel2 ? ovf2 : ovf4;

    // ---------------- scoreboard ----------------
    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] img, last4;
    logic [6:0]  glyph_t [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                  7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // image: byte i = {dp, seg A..G} of digit i (lit-high), bit 63 = overflow
    function automatic logic [63:0] model(input logic [7:0] v, input int d);
        int s, m, nd, p;
        logic neg, ovf;
        logic [63:0] r;
        s   = int'($signed(v));
        neg = (s < 0);
        m   = neg ? -s : s;
        p   = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        ovf = neg ? (m > p / 10 - 1) : (m > p - 1);
        r   = '0;
        if (ovf) begin
            r[63] = 1'b1;
            for (int i = 0; i < d; i++) r[8*i +: 8] = 8'h40;
        end else begin
            nd = 1;
            p  = 1;
            for (int i = 0; i < d; i++) begin
                if (m >= p) nd = i + 1;
                r[8*i +: 8] = (m >= p || i == 0) ? {1'b0, glyph_t[(m / p) % 10]} : 8'h00;
                p = p * 10;
            end
            if (neg) begin
                r[8*nd +: 8] = 8'h40;
                r[7] = 1'b1;
            end
        end
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic capture(input logic use2, output logic [63:0] im);
        int d, k;
        logic [3:0] want;
        sel2 = use2;
        d = use2 ? 2 : 4;
        im = '0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < d; i++) begin
            want = 4'b0001 << i;
            k = 0;
            while (dsel_l != want && k < 100) begin
                @(negedge clk);
                k++;
            end
            if (k >= 100) check("scan_timeout", 64'(k), 64'd0);
            im[8*i +: 8] = {dp_l, seg_l};
        end
        im[63] = ovf_w;
    endtask

    task automatic run_load(input logic use2, input logic [7:0] v, input logic pulse,
                            input logic [7:0] v2, output logic [63:0] im);
        int n;
        logic [63:0] e;
        sel2 = use2;
        exp_q.push_back(model(v, use2 ? 2 : 4));
        @(negedge clk);
        value = v;
        if (use2) load2 = 1'b1; else load4 = 1'b1;
        @(negedge clk);
        load2 = 1'b0;
        load4 = 1'b0;
        n = 0;
        while (busy_w === 1'b1 && n < 40) begin
            n++;
            if (pulse && n == 3) begin
                value = v2;
                if (use2) load2 = 1'b1; else load4 = 1'b1;
            end
            @(negedge clk);
            load2 = 1'b0;
            load4 = 1'b0;
        end
        check("busy_cycles", 64'(n), 64'd9);
        capture(use2, im);
        if (exp_q.size() == 0) begin
            check("queue_empty", 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            check("image", im, e);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] cur, prev;
        int n, k, bad;
        logic seen;
        logic [7:0] rv;

        rst_n = 1'b0; value = '0; load4 = 0; load2 = 0; blank = 0; duty = 3'd7; sel2 = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (13) @(negedge clk);

        // asynchronous reset mid-scan, sampled before any clock edge
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", 64'(busy4), 64'd0);
        check("rst_ovf",  64'(ovf4),  64'd0);
        check("rst_dig4", 64'(dig4),  64'hE);
        check("rst_dig2", 64'(dig2),  64'h2);
        check("rst_seg",  64'(seg4),  64'h7F);
        check("rst_dp",   64'(dp4),   64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        run_load(0, 8'h00, 0, 8'h00, img);
        run_load(0, 8'hFD, 0, 8'h00, img);
        check("neg3_const", img, 64'h0000_0000_0000_40CF);
        run_load(0, 8'h80, 0, 8'h00, img);
        check("neg128_const", img, 64'h0000_0000_4006_5BFF);
        run_load(0, 8'h7F, 0, 8'h00, img);

        run_load(1, 8'd100, 0, 8'h00, img);
        check("d2_ovf_const", img, 64'h8000_0000_0000_4040);
        run_load(1, 8'd42, 0, 8'h00, img);
        run_load(1, 8'hF7, 0, 8'h00, img);

        // load during busy is dropped
        run_load(0, 8'd57, 1, 8'd99, img);

        for (int i = 0; i < 6; i++) begin
            rv = 8'($urandom_range(0, 255));
            run_load(0, rv, 0, 8'h00, img);
        end
        for (int i = 0; i < 3; i++) begin
            rv = 8'($urandom_range(0, 255));
            run_load(1, rv, 0, 8'h00, img);
        end
        run_load(0, 8'hCE, 0, 8'h00, last4);

        // scan stepping and hold time
        sel2 = 0;
        prev = dsel_l;
        k = 0;
        while (dsel_l == prev && k < 40) begin @(negedge clk); k++; end
        for (int r = 0; r < 4; r++) begin
            cur = dsel_l;
            n = 0;
            while (dsel_l == cur && n < 40) begin @(negedge clk); n++; end
            check("scan_hold", 64'(n), 64'd8);
            check("scan_next", 64'(dsel_l), 64'({cur[2:0], cur[3]}));
        end

        // blank gates seg/dp only
        blank = 1'b1;
        repeat (2) @(negedge clk);
        bad = 0; seen = 0; prev = dsel_l;
        repeat (20) begin
            @(negedge clk);
            if (seg4 !== 7'h7F || dp4 !== 1'b1) bad++;
            if (dsel_l != prev) seen = 1;
        end
        check("blank_seg", 64'(bad), 64'd0);
        check("blank_scan", 64'(seen), 64'd1);
        blank = 1'b0;
        capture(0, img);
        check("unblank", img, last4);

        // reset during conversion aborts it and clears the display
        @(negedge clk);
        value = 8'd77;
        load4 = 1'b1;
        @(negedge clk);
        load4 = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_conv_busy", 64'(busy4), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("rst_conv_idle", 64'(busy4), 64'd0);
        capture(0, img);
        check("rst_conv_img", img, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
